// File: rtl/smm_coo_engine_pkg.sv
// smm_pkg: shared state encoding, COO entry layout and index-width helper for the SMM engine
package smm_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, CALC, EMIT, DONE} state_t;
   localparam int IDX_MAX = 6;
   localparam int VAL_MAX = 16;
   typedef struct packed {
      logic [IDX_MAX-1:0] row;
      logic [IDX_MAX-1:0] col;
      logic [VAL_MAX-1:0] val;
   } coo_entry_t;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/smm_coo_engine_if.sv
// smm_coo_engine_if: job start, COO entry streams for A/B and the ready/valid result stream
interface smm_coo_engine_if #(
   parameter int N     = 32,
   parameter int VAL_W = 4,
   parameter int OUT_W = 9
);
   localparam int IDX_W = smm_pkg::idx_w(N);
   logic             in_valid_size;
   logic [IDX_W-1:0] in_size;
   logic             in_valid_a, in_valid_b;
   logic [IDX_W-1:0] in_row_a, in_col_a, in_row_b, in_col_b;
   logic [VAL_W-1:0] in_val_a, in_val_b;
   logic             out_ready, out_valid;
   logic [IDX_W-1:0] out_row, out_col;
   logic [OUT_W-1:0] out_val;
   logic             out_done, busy, ovf;
   modport master (
      output in_valid_size, in_size, in_valid_a, in_valid_b, in_row_a, in_col_a, in_row_b, in_col_b,
             in_val_a, in_val_b, out_ready,
      input  out_valid, out_row, out_col, out_val, out_done, busy, ovf
   );
   modport slave (
      input  in_valid_size, in_size, in_valid_a, in_valid_b, in_row_a, in_col_a, in_row_b, in_col_b,
             in_val_a, in_val_b, out_ready,
      output out_valid, out_row, out_col, out_val, out_done, busy, ovf
   );
endinterface

// File: rtl/smm_coo_buf.sv
// smm_coo_buf: NNZ-deep COO entry list with append, count, full flag, random read and clear
module smm_coo_buf import smm_pkg::*; #(
   parameter int NNZ = 64,
   localparam int AW = idx_w(NNZ),
   localparam int CW = $clog2(NNZ + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clr,
   input  logic       i_wr,
   input  coo_entry_t i_wdata,
   input  logic [AW-1:0] i_raddr,
   output coo_entry_t o_rdata,
   output logic [CW-1:0] o_cnt,
   output logic       o_full
);
   coo_entry_t r_mem [NNZ];
   logic [CW-1:0] r_cnt;

   assign o_full  = r_cnt == CW'(NNZ);
   assign o_cnt   = r_cnt;
   assign o_rdata = r_mem[i_raddr];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_wr && !o_full) r_cnt <= r_cnt + CW'(1);

   // storage needs no reset: only entries below the count are ever read
   always_ff @(posedge clk)
      if (i_wr && !o_full) r_mem[r_cnt[AW-1:0]] <= i_wdata;
endmodule

// File: rtl/smm_coo_engine.sv
// smm_coo_engine: sparse COO matrix multiplier, C = A x B row by row, one MAC per cycle
// Define SMM_SAT_EN for saturating accumulation (flags ovf); otherwise accumulators wrap.
module smm_coo_engine import smm_pkg::*; #(
   parameter int N     = 32,
   parameter int VAL_W = 4,
   parameter int OUT_W = 9,
   parameter int NNZ   = 64
) (
   input logic clk,
   input logic rst_n,
   smm_coo_engine_if.slave bus
);
   localparam int IDX_W = idx_w(N);
   localparam int AW    = idx_w(NNZ);
   localparam int CW    = $clog2(NNZ + 1);

   state_t r_state, w_next;
   logic [IDX_W-1:0] r_size, r_row, r_col, r_out_row, r_out_col;
   logic [OUT_W-1:0] r_acc [N];
   logic [OUT_W-1:0] r_out_val, w_cur, w_prod, w_acc_cur, w_acc_nx;
   logic [AW-1:0]    r_pa, r_pb;
   logic             r_out_valid, r_ovf;
   coo_entry_t       w_wa, w_wb, w_a, w_b;
   logic [CW-1:0]    w_cnt_a, w_cnt_b;
   logic w_full_a, w_full_b, w_ld, w_clr, w_ok_a, w_ok_b, w_drop;
   logic w_hit, w_a_last, w_b_last, w_pa_step, w_calc_end, w_mac, w_sat;
   logic w_slot, w_adv, w_load, w_col_end;

   assign w_ld   = r_state == LOAD;
   assign w_clr  = r_state == IDLE && bus.in_valid_size;
   assign w_ok_a = bus.in_valid_a && bus.in_row_a <= r_size && bus.in_col_a <= r_size;
   assign w_ok_b = bus.in_valid_b && bus.in_row_b <= r_size && bus.in_col_b <= r_size;
   assign w_drop = w_ld && ((bus.in_valid_a && (!w_ok_a || w_full_a)) ||
                            (bus.in_valid_b && (!w_ok_b || w_full_b)));
   assign w_wa = '{row: IDX_MAX'(bus.in_row_a), col: IDX_MAX'(bus.in_col_a), val: VAL_MAX'(bus.in_val_a)};
   assign w_wb = '{row: IDX_MAX'(bus.in_row_b), col: IDX_MAX'(bus.in_col_b), val: VAL_MAX'(bus.in_val_b)};

   smm_coo_buf #(.NNZ(NNZ)) u_buf_a (
      .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_wr(w_ld && w_ok_a), .i_wdata(w_wa),
      .i_raddr(r_pa), .o_rdata(w_a), .o_cnt(w_cnt_a), .o_full(w_full_a)
   );
   smm_coo_buf #(.NNZ(NNZ)) u_buf_b (
      .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_wr(w_ld && w_ok_b), .i_wdata(w_wb),
      .i_raddr(r_pb), .o_rdata(w_b), .o_cnt(w_cnt_b), .o_full(w_full_b)
   );

   // an A entry of the current row holds pa while pb sweeps all of B
   assign w_hit      = w_a.row == IDX_MAX'(r_row) && w_cnt_b != '0;
   assign w_a_last   = CW'(r_pa) == w_cnt_a - CW'(1);
   assign w_b_last   = CW'(r_pb) == w_cnt_b - CW'(1);
   assign w_pa_step  = !w_hit || w_b_last;
   assign w_calc_end = w_cnt_a == '0 || (w_pa_step && w_a_last);
   assign w_mac      = r_state == CALC && w_cnt_a != '0 && w_hit && w_b.row == w_a.col;
   assign w_prod     = OUT_W'(w_a.val) * OUT_W'(w_b.val);
   assign w_acc_cur  = r_acc[IDX_W'(w_b.col)];
`ifdef SMM_SAT_EN
   logic [OUT_W:0] w_sum;
   assign w_sum    = {1'b0, w_acc_cur} + {1'b0, w_prod};
   assign w_acc_nx = w_sum[OUT_W] ? '1 : w_sum[OUT_W-1:0];
   assign w_sat    = w_mac && w_sum[OUT_W];
`else
   assign w_acc_nx = w_acc_cur + w_prod;
   assign w_sat    = 1'b0;
`endif

   // a nonzero column waits only for a free output slot, so zero columns never stall
   assign w_cur     = r_acc[r_col];
   assign w_slot    = !r_out_valid || bus.out_ready;
   assign w_adv     = r_state == EMIT && (w_cur == '0 || w_slot);
   assign w_load    = r_state == EMIT && w_cur != '0 && w_slot;
   assign w_col_end = r_col == r_size;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid_size) w_next = LOAD;
         LOAD:    if (!bus.in_valid_a && !bus.in_valid_b) w_next = CALC;
         CALC:    if (w_calc_end) w_next = EMIT;
         EMIT:    if (w_adv && w_col_end) w_next = (r_row == r_size) ? DONE : CALC;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_next;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_size <= '0;
         r_row  <= '0;
         r_col  <= '0;
         r_pa   <= '0;
         r_pb   <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_clr) r_size <= bus.in_size;
         if (w_clr) r_ovf <= 1'b0;
         else if (w_drop || w_sat) r_ovf <= 1'b1;
         if (w_ld) begin
            r_row <= '0;
            r_col <= '0;
            r_pa  <= '0;
            r_pb  <= '0;
         end
         if (r_state == CALC && w_cnt_a != '0) begin
            if (w_hit) r_pb <= w_b_last ? '0 : r_pb + AW'(1);
            if (w_pa_step) r_pa <= w_a_last ? '0 : r_pa + AW'(1);
         end
         if (w_adv) r_col <= w_col_end ? '0 : r_col + IDX_W'(1);
         if (w_adv && w_col_end) r_row <= r_row + IDX_W'(1);
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_row   <= '0;
         r_out_col   <= '0;
         r_out_val   <= '0;
         for (int i = 0; i < N; i++) r_acc[i] <= '0;
      end else begin
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_row   <= r_row;
            r_out_col   <= r_col;
            r_out_val   <= w_cur;
         end else if (bus.out_ready) r_out_valid <= 1'b0;
         if (w_mac) r_acc[IDX_W'(w_b.col)] <= w_acc_nx;
         else if (w_load) r_acc[r_col] <= '0;
      end

   assign bus.out_valid = r_out_valid;
   assign bus.out_row   = r_out_row;
   assign bus.out_col   = r_out_col;
   assign bus.out_val   = r_out_val;
   assign bus.out_done  = r_state == DONE;
   assign bus.busy      = r_state != IDLE;
   assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_smm_coo_engine.sv
// tb_smm_coo_engine: directed jobs against a dense reference model with a result-beat scoreboard
module tb_smm_coo_engine;
   import smm_pkg::*;
   localparam int N = 32, VAL_W = 4, OUT_W = 9, NNZ = 64;
   localparam int IDX_W = idx_w(N);
   localparam int MOD = 1 << OUT_W;

   typedef struct {int r; int c; int v;} ent_t;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   smm_coo_engine_if #(.N(N), .VAL_W(VAL_W), .OUT_W(OUT_W)) bus ();
   smm_coo_engine_if #(.N(N), .VAL_W(VAL_W), .OUT_W(OUT_W)) bus_s ();
   smm_coo_engine #(.N(N), .VAL_W(VAL_W), .OUT_W(OUT_W), .NNZ(NNZ)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   smm_coo_engine #(.N(N), .VAL_W(VAL_W), .OUT_W(OUT_W), .NNZ(4)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

   ent_t qa[$], qb[$], ka[$], kb[$], exp_q[$];
   int n_cmp = 0, n_bad = 0, exp_lat = 0;
   logic exp_ovf = 1'b0;
   logic [IDX_W-1:0] h_r, h_c;
   logic [OUT_W-1:0] h_v;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic add_a(input int r, input int c, input int v);
      qa.push_back('{r, c, v});
   endtask

   task automatic add_b(input int r, input int c, input int v);
      qb.push_back('{r, c, v});
   endtask

   task automatic model(input int d);
      int acc[N];
      int calc;
      ka.delete(); kb.delete();
      exp_ovf = 1'b0;
      exp_lat = 1;
      foreach (qa[i]) if (qa[i].r < d && qa[i].c < d && ka.size() < NNZ) ka.push_back(qa[i]); else exp_ovf = 1'b1;
      foreach (qb[i]) if (qb[i].r < d && qb[i].c < d && kb.size() < NNZ) kb.push_back(qb[i]); else exp_ovf = 1'b1;
      for (int r = 0; r < d; r++) begin
         int k = 0;
         for (int c = 0; c < d; c++) acc[c] = 0;
         foreach (ka[i]) if (ka[i].r == r) begin
            k++;
            foreach (kb[j]) if (kb[j].r == ka[i].c) begin
               int s = acc[kb[j].c] + (ka[i].v * kb[j].v) % MOD;
`ifdef SMM_SAT_EN
               if (s >= MOD) begin s = MOD - 1; exp_ovf = 1'b1; end
`else
               s = s % MOD;
`endif
               acc[kb[j].c] = s;
            end
         end
         calc = ka.size() == 0 ? 1 : ka.size() + k * (kb.size() == 0 ? 0 : kb.size() - 1);
         exp_lat += calc + d;
         for (int c = 0; c < d; c++) if (acc[c] != 0) exp_q.push_back('{r, c, acc[c]});
      end
   endtask

   task automatic send(input int d);
      int m;
      model(d);
      m = qa.size() > qb.size() ? qa.size() : qb.size();
      @(posedge clk); #1;
      bus.in_valid_size = 1'b1;
      bus.in_size = IDX_W'(d - 1);
      @(posedge clk); #1;
      bus.in_valid_size = 1'b0;
      for (int i = 0; i < m; i++) begin
         bus.in_valid_a = i < qa.size();
         bus.in_valid_b = i < qb.size();
         if (i < qa.size()) begin
            bus.in_row_a = IDX_W'(qa[i].r); bus.in_col_a = IDX_W'(qa[i].c); bus.in_val_a = VAL_W'(qa[i].v);
         end
         if (i < qb.size()) begin
            bus.in_row_b = IDX_W'(qb[i].r); bus.in_col_b = IDX_W'(qb[i].c); bus.in_val_b = VAL_W'(qb[i].v);
         end
         @(posedge clk); #1;
      end
      bus.in_valid_a = 1'b0;
      bus.in_valid_b = 1'b0;
      qa.delete(); qb.delete();
   endtask

   task automatic wait_done(input string tag, input bit chk_lat);
      int k = 0;
      @(negedge clk);
      while (!bus.out_done && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_done"}, bus.out_done, 1);
      if (chk_lat) chk({tag, "_latency"}, k, exp_lat);
      chk({tag, "_ovf"}, bus.ovf, exp_ovf);
      @(negedge clk);
      chk({tag, "_done_pulse"}, bus.out_done, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_beats_left"}, exp_q.size(), 0);
   endtask

   task automatic wait_valid(input string tag);
      int t = 0;
      while (!bus.out_valid && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_valid"}, bus.out_valid, 1);
   endtask

   always @(negedge clk) begin : mon
      ent_t e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         n_cmp++;
         assert (exp_q.size() > 0) else begin
            n_bad++;
            $error("FAIL beat_extra: observed (%0d,%0d,%0d) expected no beat", bus.out_row, bus.out_col, bus.out_val);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat_row", bus.out_row, e.r);
            chk("beat_col", bus.out_col, e.c);
            chk("beat_val", bus.out_val, e.v);
         end
      end
   end

   initial begin
      {bus.in_valid_size, bus.in_valid_a, bus.in_valid_b} = '0;
      {bus.in_size, bus.in_row_a, bus.in_col_a, bus.in_row_b, bus.in_col_b, bus.in_val_a, bus.in_val_b} = '0;
      bus.out_ready = 1'b1;
      {bus_s.in_valid_size, bus_s.in_valid_a, bus_s.in_valid_b} = '0;
      {bus_s.in_size, bus_s.in_row_a, bus_s.in_col_a, bus_s.in_row_b, bus_s.in_col_b, bus_s.in_val_a, bus_s.in_val_b} = '0;
      bus_s.out_ready = 1'b1;
      #2;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", {bus.out_row, bus.out_col, bus.out_val}, 0);
      chk("rst_done", bus.out_done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ovf", bus.ovf, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      add_a(0, 0, 3); add_a(1, 1, 2); add_b(0, 1, 5); add_b(1, 0, 4);
      send(2);
      wait_done("basic", 1'b1);

      add_a(0, 2, 3); add_b(0, 1, 2); add_b(1, 3, 4);
      send(4);
      wait_done("zero_row", 1'b1);

      add_a(0, 0, 1); add_a(0, 0, 1); add_b(0, 0, 7);
      send(2);
      wait_done("dup", 1'b1);

      add_a(0, 0, 2); add_a(2, 0, 9); add_b(0, 0, 3); add_b(0, 3, 1);
      send(2);
      wait_done("range_drop", 1'b1);

      send(3);
      wait_done("empty", 1'b1);

      for (int i = 0; i < 40; i++) add_a(0, 0, 15);
      add_b(0, 0, 15);
      send(1);
      wait_done("accum_limit", 1'b1);

      bus.out_ready = 1'b0;
      add_a(0, 0, 3); add_a(1, 1, 2); add_b(0, 1, 5); add_b(1, 0, 4);
      send(2);
      wait_valid("stall");
      h_r = bus.out_row; h_c = bus.out_col; h_v = bus.out_val;
      repeat (5) begin
         @(negedge clk);
         chk("stall_hold", {bus.out_valid, bus.out_row, bus.out_col, bus.out_val}, {1'b1, h_r, h_c, h_v});
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      wait_done("stall", 1'b0);

      bus.out_ready = 1'b0;
      add_a(0, 0, 3); add_a(1, 1, 2); add_b(0, 1, 5); add_b(1, 0, 4);
      send(2);
      wait_valid("pre_rst");
      repeat (6) @(negedge clk);
      chk("pre_rst_busy", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_busy", bus.busy, 0);
      exp_q.delete();
      bus.out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      add_a(0, 0, 3); add_a(1, 1, 2); add_b(0, 1, 5); add_b(1, 0, 4);
      send(2);
      wait_done("after_rst", 1'b1);

      @(posedge clk); #1;
      bus_s.in_valid_size = 1'b1;
      bus_s.in_size = '0;
      @(posedge clk); #1;
      bus_s.in_valid_size = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus_s.in_valid_a = 1'b1; bus_s.in_row_a = '0; bus_s.in_col_a = '0; bus_s.in_val_a = VAL_W'(i + 1);
         bus_s.in_valid_b = i == 0; bus_s.in_row_b = '0; bus_s.in_col_b = '0; bus_s.in_val_b = VAL_W'(1);
         @(posedge clk); #1;
      end
      bus_s.in_valid_a = 1'b0;
      bus_s.in_valid_b = 1'b0;
      begin
         int t = 0;
         while (!bus_s.out_valid && t < 500) begin
            @(negedge clk);
            t++;
         end
         chk("full_valid", bus_s.out_valid, 1);
         chk("full_beat", {bus_s.out_row, bus_s.out_col, bus_s.out_val}, {IDX_W'(0), IDX_W'(0), OUT_W'(10)});
         chk("full_ovf", bus_s.ovf, 1);
         t = 0;
         while (!bus_s.out_done && t < 500) begin
            @(negedge clk);
            t++;
         end
         chk("full_done", bus_s.out_done, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
